pc_stack_unit: RTL

//  Parametrised program-counter and subroutine-stack unit for the 4-bit core family.

---
 rtl/pc_stack_if.sv | 46 ++++
 rtl/pc_stack_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pc_stack_if.sv
// pc_stack_if
//   Command/status bundle between the core sequencer and pc_stack_unit.
//   master: sequencer side (drives step/cmd/cmd_tgt/cmd_page/clr_flags,
//           observes PC, skip and stack status).
//   slave : pc_stack_unit side.
//   Signals:
//     step       advance one instruction this cycle
//     cmd        0 SEQ, 1 JMP, 2 CALL, 3 RET, 4 RETSK, 5 SETPAGE, 6/7 SEQ
//     cmd_tgt    JMP/CALL in-page target
//     cmd_page   SETPAGE page value
//     clr_flags  clear sticky ovf/udf
//     pc_out     current PC {PU,PL}
//     skip_out   high for one step after RETSK
//     depth_cnt  stack occupancy 0..DEPTH
//     full/empty occupancy at DEPTH / at 0
//     ovf/udf    sticky push-when-full / pop-when-empty
interface pc_stack_if #(
   parameter int PL_W  = 6,
   parameter int PU_W  = 4,
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                 step;
   logic [2:0]           cmd;
   logic [PL_W-1:0]      cmd_tgt;
   logic [PU_W-1:0]      cmd_page;
   logic                 clr_flags;
   logic [PU_W+PL_W-1:0] pc_out;
   logic                 skip_out;
   logic [CNT_W-1:0]     depth_cnt;
   logic                 full;
   logic                 empty;
   logic                 ovf;
   logic                 udf;

   modport master (
      output step, cmd, cmd_tgt, cmd_page, clr_flags,
      input  pc_out, skip_out, depth_cnt, full, empty, ovf, udf
   );

   modport slave (
      input  step, cmd, cmd_tgt, cmd_page, clr_flags,
      output pc_out, skip_out, depth_cnt, full, empty, ovf, udf
   );
endinterface

// File: rtl/pc_stack_unit.sv
// pc_stack_unit
//   Program counter {PU,PL} with LFSR or binary in-page advance, a DEPTH-entry
//   return stack with occupancy and sticky overflow/underflow flags, and a
//   one-instruction SETPAGE prefix that redirects the next JMP/CALL.
//   Ports:
//     clk    clock, all updates on posedge
//     RESET  asynchronous, active-low reset
//     bus    pc_stack_if slave modport (commands in, PC/status out)
module pc_stack_unit #(
   parameter int             PL_W      = 6,
   parameter int             PU_W      = 4,
   parameter int             DEPTH     = 4,
   parameter bit             LFSR_MODE = 1'b1,
   parameter logic [PU_W-1:0] CALL_PAGE = {PU_W{1'b1}}
) (
   input logic        clk,
   input logic        RESET,
   pc_stack_if.slave  bus
);
   localparam int PC_W  = PU_W + PL_W;
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [2:0] CMD_JMP     = 3'd1;
   localparam logic [2:0] CMD_CALL    = 3'd2;
   localparam logic [2:0] CMD_RET     = 3'd3;
   localparam logic [2:0] CMD_RETSK   = 3'd4;
   localparam logic [2:0] CMD_SETPAGE = 3'd5;

   logic [PL_W-1:0]  pl_q, pl_d;
   logic [PU_W-1:0]  pu_q, pu_d;
   logic [PC_W-1:0]  stk_q [DEPTH];
   logic [PC_W-1:0]  stk_d [DEPTH];
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic [PU_W-1:0]  ppage_q, ppage_d;
   logic             skip_q, skip_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;

   logic             full_w;
   logic             empty_w;
   logic [PL_W-1:0]  pl_nxt;
   logic [PC_W-1:0]  top_w;

   assign full_w  = (cnt_q == CNT_W'(DEPTH));
   assign empty_w = (cnt_q == '0);

   // In-page sequential successor. The XNOR-feedback LFSR locks up at
   // all-ones, so that state is forced back to 0.
   always_comb begin
      pl_nxt = pl_q + 1'b1;
      if (LFSR_MODE) begin
         if (&pl_q) pl_nxt = '0;
         else       pl_nxt = {pl_q[0] ~^ pl_q[1], pl_q[PL_W-1:1]};
      end
   end

   // Top-of-stack lives at index cnt_q-1.
   always_comb begin
      top_w = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (cnt_q == CNT_W'(i + 1)) top_w = stk_q[i];
      end
   end

   always_comb begin
      pl_d    = pl_q;
      pu_d    = pu_q;
      stk_d   = stk_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      ppage_d = ppage_q;
      skip_d  = skip_q;
      ovf_d   = bus.clr_flags ? 1'b0 : ovf_q;
      udf_d   = bus.clr_flags ? 1'b0 : udf_q;

      if (bus.step) begin
         // Prefix and skip each live for exactly one step.
         pend_d = 1'b0;
         skip_d = 1'b0;
         pl_d   = pl_nxt;
         unique case (bus.cmd)
            CMD_JMP: begin
               pl_d = bus.cmd_tgt;
               if (pend_q) pu_d = ppage_q;
            end
            CMD_CALL: begin
               if (full_w) begin
                  // Drop the oldest entry to make room at the top.
                  for (int i = 0; i < DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
                  stk_d[DEPTH-1] = {pu_q, pl_nxt};
                  ovf_d          = 1'b1;
               end else begin
                  for (int i = 0; i < DEPTH; i++) begin
                     if (cnt_q == CNT_W'(i)) stk_d[i] = {pu_q, pl_nxt};
                  end
                  cnt_d = cnt_q + 1'b1;
               end
               pl_d = bus.cmd_tgt;
               pu_d = pend_q ? ppage_q : CALL_PAGE;
            end
            CMD_RET, CMD_RETSK: begin
               if (empty_w) begin
                  pl_d  = '0;
                  pu_d  = '0;
                  udf_d = 1'b1;
               end else begin
                  pl_d = top_w[PL_W-1:0];
                  pu_d = top_w[PC_W-1:PL_W];
                  for (int i = 0; i < DEPTH; i++) begin
                     if (cnt_q == CNT_W'(i + 1)) stk_d[i] = '0;
                  end
                  cnt_d = cnt_q - 1'b1;
               end
               skip_d = (bus.cmd == CMD_RETSK);
            end
            CMD_SETPAGE: begin
               ppage_d = bus.cmd_page;
               pend_d  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         pl_q    <= '0;
         pu_q    <= '0;
         for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         ppage_q <= '0;
         skip_q  <= 1'b0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         pl_q    <= pl_d;
         pu_q    <= pu_d;
         stk_q   <= stk_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ppage_q <= ppage_d;
         skip_q  <= skip_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   assign bus.pc_out    = {pu_q, pl_q};
   assign bus.skip_out  = skip_q;
   assign bus.depth_cnt = cnt_q;
   assign bus.full      = full_w;
   assign bus.empty     = empty_w;
   assign bus.ovf       = ovf_q;
   assign bus.udf       = udf_q;
endmodule
